// File: rtl/arm_regfile_banked_pkg.sv
// rtl/arm_regfile_banked_pkg.sv - shared constants, mode type and bank mapping for the banked register file
package arm_rf_pkg;

  localparam logic [3:0] REG_SP = 4'd13;
  localparam logic [3:0] REG_LR = 4'd14;
  localparam logic [3:0] REG_PC = 4'd15;

  // Slots 0..14 hold R0-R14 (user bank); slots 15/16 hold SP_irq/LR_irq.
  localparam int         NUM_SLOTS   = 17;
  localparam logic [4:0] LR_IRQ_SLOT = 5'd16;

  typedef enum logic {MODE_USR = 1'b0, MODE_IRQ = 1'b1} mode_t;

  function automatic logic [4:0] bank_index(input logic [3:0] addr, input mode_t mode);
    if (mode == MODE_IRQ && (addr == REG_SP || addr == REG_LR))
      return {1'b0, addr} + 5'd2;
    return {1'b0, addr};
  endfunction

endpackage

// File: rtl/arm_regfile_banked_if.sv
// rtl/arm_regfile_banked_if.sv - control-FSM to register-file connection bundle
interface arm_regfile_banked_if #(
  parameter int DATA_W = 32,
  parameter int NRD    = 2
);
  logic [NRD*4-1:0]      rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic                  wr_en;
  logic [3:0]            wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic                  pc_we;
  logic [DATA_W-1:0]     pc_next;
  logic                  irq_enter;
  logic                  irq_exit;
  logic                  irq_mode;
  logic [DATA_W-1:0]     pc;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, pc_we, pc_next, irq_enter, irq_exit,
    input  rd_data, irq_mode, pc
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, pc_we, pc_next, irq_enter, irq_exit,
    output rd_data, irq_mode, pc
  );
endinterface

// File: rtl/arm_regfile_banked_readport.sv
// rtl/arm_regfile_banked_readport.sv - one combinational read port: bank select, write bypass, PC offset
module arm_rf_readport
  import arm_rf_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                BYPASS      = 1,
  parameter logic [DATA_W-1:0] PC_READ_OFS = '0
) (
  input  logic [3:0]                  addr,
  input  mode_t                       mode,
  input  logic [NUM_SLOTS*DATA_W-1:0] regs_flat,
  input  logic [DATA_W-1:0]           pc,
  input  logic                        wr_en,
  input  logic [3:0]                  wr_addr,
  input  logic [DATA_W-1:0]           wr_data,
  output logic [DATA_W-1:0]           data
);

  logic [4:0] slot;

  always_comb begin
    slot = bank_index(addr, mode);
    data = regs_flat[int'(slot)*DATA_W +: DATA_W];
    // R15 never bypasses: its writes go through the PC priority path.
    if (addr == REG_PC)
      data = pc + PC_READ_OFS;
    else if (BYPASS != 0 && wr_en && wr_addr == addr)
      data = wr_data;
  end

endmodule

// File: rtl/arm_regfile_banked.sv
// rtl/arm_regfile_banked.sv - mode-banked ARM register file with N read ports, PC priority and IRQ LR capture
module arm_regfile_banked
  import arm_rf_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                NRD         = 2,
  parameter int                BYPASS      = 1,
  parameter logic [DATA_W-1:0] RESET_PC    = '0,
  parameter logic [DATA_W-1:0] PC_READ_OFS = '0
) (
  input logic                  clk,
  input logic                  reset,
  arm_regfile_banked_if.slave  bus
);

  logic [DATA_W-1:0]           regs [NUM_SLOTS];
  logic [NUM_SLOTS*DATA_W-1:0] regs_flat;
  logic [DATA_W-1:0]           pc_q;
  mode_t                       mode;
  logic [4:0]                  wslot;
  logic                        enter_ok;
  logic                        exit_ok;
  logic [NRD*DATA_W-1:0]       rd_data_w;

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_flat
    assign regs_flat[i*DATA_W +: DATA_W] = regs[i];
  end

  // Simultaneous enter/exit cancel out; pulses that do not match the mode are ignored.
  assign enter_ok = bus.irq_enter && !bus.irq_exit && (mode == MODE_USR);
  assign exit_ok  = bus.irq_exit && !bus.irq_enter && (mode == MODE_IRQ);
  assign wslot    = bank_index(bus.wr_addr, mode);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) regs[i] <= '0;
      pc_q <= RESET_PC;
      mode <= MODE_USR;
    end else begin
      if (bus.wr_en && bus.wr_addr != REG_PC)
        regs[wslot] <= bus.wr_data;
      // Entry only happens from USR, so a same-cycle R14 write lands in LR_usr.
      if (enter_ok)
        regs[LR_IRQ_SLOT] <= pc_q;

      if (bus.wr_en && bus.wr_addr == REG_PC)
        pc_q <= bus.wr_data;
      else if (bus.pc_we)
        pc_q <= bus.pc_next;

      case (mode)
        MODE_USR: if (enter_ok) mode <= MODE_IRQ;
        MODE_IRQ: if (exit_ok)  mode <= MODE_USR;
        default:  mode <= MODE_USR;
      endcase
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    arm_rf_readport #(
      .DATA_W      (DATA_W),
      .BYPASS      (BYPASS),
      .PC_READ_OFS (PC_READ_OFS)
    ) u_rd (
      .addr      (bus.rd_addr[4*k +: 4]),
      .mode      (mode),
      .regs_flat (regs_flat),
      .pc        (pc_q),
      .wr_en     (bus.wr_en),
      .wr_addr   (bus.wr_addr),
      .wr_data   (bus.wr_data),
      .data      (rd_data_w[DATA_W*k +: DATA_W])
    );
  end

  assign bus.rd_data  = rd_data_w;
  assign bus.pc       = pc_q;
  assign bus.irq_mode = (mode == MODE_IRQ);

endmodule

// File: tb/tb_arm_regfile_banked.sv
// tb/tb_arm_regfile_banked.sv - scoreboard bench: two DUT builds (bypass+offset, no-bypass) on shared stimulus
module tb_arm_regfile_banked;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rd_addr;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        pc_we;
  logic [31:0] pc_next;
  logic        irq_enter;
  logic        irq_exit;

  int cycle = 0;
  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] value;
    int          cyc;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  arm_regfile_banked_if #(.DATA_W(32), .NRD(2)) ifa ();
  arm_regfile_banked_if #(.DATA_W(32), .NRD(2)) ifb ();

  assign ifa.rd_addr = rd_addr;   assign ifb.rd_addr = rd_addr;
  assign ifa.wr_en = wr_en;       assign ifb.wr_en = wr_en;
  assign ifa.wr_addr = wr_addr;   assign ifb.wr_addr = wr_addr;
  assign ifa.wr_data = wr_data;   assign ifb.wr_data = wr_data;
  assign ifa.pc_we = pc_we;       assign ifb.pc_we = pc_we;
  assign ifa.pc_next = pc_next;   assign ifb.pc_next = pc_next;
  assign ifa.irq_enter = irq_enter; assign ifb.irq_enter = irq_enter;
  assign ifa.irq_exit = irq_exit; assign ifb.irq_exit = irq_exit;

  arm_regfile_banked #(
    .DATA_W(32), .NRD(2), .BYPASS(1), .RESET_PC(32'h0), .PC_READ_OFS(32'h8)
  ) dut_a (.clk(clk), .reset(reset), .bus(ifa));

  arm_regfile_banked #(
    .DATA_W(32), .NRD(2), .BYPASS(0), .RESET_PC(32'h100), .PC_READ_OFS(32'h0)
  ) dut_b (.clk(clk), .reset(reset), .bus(ifb));

  // sel: 0/1 = A ports, 2 = A pc, 3 = A mode, 4/5 = B ports, 6 = B pc, 7 = B mode
  function automatic logic [31:0] actual(input int sel);
    case (sel)
      0: return ifa.rd_data[31:0];
      1: return ifa.rd_data[63:32];
      2: return ifa.pc;
      3: return {31'b0, ifa.irq_mode};
      4: return ifb.rd_data[31:0];
      5: return ifb.rd_data[63:32];
      6: return ifb.pc;
      default: return {31'b0, ifb.irq_mode};
    endcase
  endfunction

  task automatic expect_sig(input string nm, input int sel, input logic [31:0] v);
    exp_t e;
    e.name = nm; e.sel = sel; e.value = v; e.cyc = cycle;
    q.push_back(e);
  endtask

  task automatic expect_both(input string nm, input int sel, input logic [31:0] va,
                             input logic [31:0] vb);
    expect_sig({nm, "_a"}, sel, va);
    expect_sig({nm, "_b"}, sel + 4, vb);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    wr_en = 1'b0; pc_we = 1'b0; irq_enter = 1'b0; irq_exit = 1'b0;
  endtask

  // Monitor: outputs are combinational/registered, so every cycle presents a result.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cycle) begin
      exp_t e;
      logic [31:0] a;
      e = q.pop_front();
      a = actual(e.sel);
      n_total++;
      if (e.cyc != cycle)
        $display("FAIL %s: stale expectation (cycle %0d, now %0d)", e.name, e.cyc, cycle);
      else if (a !== e.value)
        $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, a, e.value);
      else
        n_pass++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; rd_addr = 8'h00; wr_en = 1'b0; wr_addr = 4'd0; wr_data = '0;
    pc_we = 1'b0; pc_next = '0; irq_enter = 1'b0; irq_exit = 1'b0;

    step(); step();
    rd_addr = {4'd15, 4'd3};
    expect_both("rst_r3", 0, 32'h0, 32'h0);
    expect_both("rst_r15", 1, 32'h8, 32'h100);
    expect_both("rst_pc", 2, 32'h0, 32'h100);
    expect_both("rst_mode", 3, 32'h0, 32'h0);

    step(); reset = 1'b0;
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'hDEADBEEF; rd_addr = {4'd3, 4'd3};
    expect_both("byp_p0", 0, 32'hDEADBEEF, 32'h0);
    expect_both("byp_p1", 1, 32'hDEADBEEF, 32'h0);

    step(); rd_addr = {4'd3, 4'd3};
    expect_both("wr_p0", 0, 32'hDEADBEEF, 32'hDEADBEEF);
    expect_both("wr_p1", 1, 32'hDEADBEEF, 32'hDEADBEEF);

    step(); pc_we = 1'b1; pc_next = 32'h104;
    wr_en = 1'b1; wr_addr = 4'd15; wr_data = 32'h2000; rd_addr = {4'd15, 4'd15};
    expect_both("r15_nobyp", 0, 32'h8, 32'h100);

    step(); pc_we = 1'b1; pc_next = 32'h104;
    expect_both("pc_prio", 2, 32'h2000, 32'h2000);

    step();
    expect_both("pc_we", 2, 32'h104, 32'h104);
    expect_both("r15_ofs", 0, 32'h10C, 32'h104);

    step(); pc_we = 1'b1; pc_next = 32'h40;
    wr_en = 1'b1; wr_addr = 4'd14; wr_data = 32'h11;
    step(); wr_en = 1'b1; wr_addr = 4'd13; wr_data = 32'h700;
    expect_both("pc_40", 2, 32'h40, 32'h40);

    step(); irq_enter = 1'b1; pc_we = 1'b1; pc_next = 32'h44; rd_addr = {4'd14, 4'd13};
    expect_both("usr_lr", 1, 32'h11, 32'h11);
    expect_both("usr_sp", 0, 32'h700, 32'h700);
    expect_both("pre_mode", 3, 32'h0, 32'h0);

    step(); irq_enter = 1'b1;
    expect_both("irq_mode", 3, 32'h1, 32'h1);
    expect_both("irq_lr", 1, 32'h40, 32'h40);
    expect_both("irq_sp0", 0, 32'h0, 32'h0);

    step(); wr_en = 1'b1; wr_addr = 4'd13; wr_data = 32'h900;
    expect_both("lr_kept", 1, 32'h40, 32'h40);
    expect_both("irq_sp_byp", 0, 32'h900, 32'h0);

    step(); irq_exit = 1'b1;
    expect_both("irq_sp", 0, 32'h900, 32'h900);
    expect_both("mode_pre_exit", 3, 32'h1, 32'h1);

    step();
    expect_both("exit_mode", 3, 32'h0, 32'h0);
    expect_both("exit_lr", 1, 32'h11, 32'h11);
    expect_both("exit_sp", 0, 32'h700, 32'h700);

    step(); irq_enter = 1'b1; irq_exit = 1'b1;
    step(); irq_exit = 1'b1;
    expect_both("both_mode", 3, 32'h0, 32'h0);
    step();
    expect_both("usr_exit_mode", 3, 32'h0, 32'h0);
    expect_both("both_lr", 1, 32'h11, 32'h11);

    step(); irq_enter = 1'b1; wr_en = 1'b1; wr_addr = 4'd14; wr_data = 32'h55;
    step(); irq_exit = 1'b1;
    expect_both("enter2_mode", 3, 32'h1, 32'h1);
    expect_both("enter2_lr", 1, 32'h44, 32'h44);
    step();
    expect_both("lr_usr_wr", 1, 32'h55, 32'h55);

    for (int r = 0; r < 15; r++) begin
      step(); wr_en = 1'b1; wr_addr = 4'(r); wr_data = 32'h1000 + r;
    end
    step(); rd_addr = {4'd12, 4'd0}; irq_enter = 1'b1;
    expect_both("fill_r0", 0, 32'h1000, 32'h1000);
    expect_both("fill_r12", 1, 32'h100C, 32'h100C);
    step(); rd_addr = {4'd14, 4'd13};
    expect_both("fill_mode", 3, 32'h1, 32'h1);
    expect_both("fill_irq_sp", 0, 32'h900, 32'h900);
    expect_both("fill_irq_lr", 1, 32'h44, 32'h44);

    step(); #2; reset = 1'b1;
    expect_both("arst_sp", 0, 32'h0, 32'h0);
    expect_both("arst_lr", 1, 32'h0, 32'h0);
    expect_both("arst_mode", 3, 32'h0, 32'h0);
    expect_both("arst_pc", 2, 32'h0, 32'h100);

    for (int r = 0; r < 8; r++) begin
      step(); rd_addr = {4'(2*r+1), 4'(2*r)};
      expect_both("rst_even", 0, 32'h0, 32'h0);
      if (r == 7) expect_both("rst_pcrd", 1, 32'h8, 32'h100);
      else        expect_both("rst_odd", 1, 32'h0, 32'h0);
    end

    step(); reset = 1'b0;
    step(); step();
    if (q.size() != 0) begin
      n_total++;
      $display("FAIL queue_drain: %0d expectations left, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
